// File: rtl/dsp_cfg_pkg.sv
// Shared types and reset defaults for the DSP configuration sequencer.
package dsp_cfg_pkg;

    localparam logic [3:0] FREQ_RST  = 4'b0001;
    localparam logic [3:0] SCALE_RST = 4'b0001;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_PKT = 2'd1;
    localparam logic [1:0] ST_APPLY    = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        WAIT_PKT = ST_WAIT_PKT,
        APPLY    = ST_APPLY,
        FLUSH    = ST_FLUSH
    } state_e;

    typedef struct packed {
        logic [3:0] freq;
        logic [3:0] scale;
    } cfg_t;

endpackage

// File: rtl/dsp_cfg_sequencer_debouncer.sv
// Multi-flop synchroniser followed by a hold-time debouncer for a switch bus.
module sw_debouncer #(
    parameter int               WIDTH   = 8,
    parameter int               STAGES  = 2,
    parameter int               CYCLES  = 1024,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_stable
);

    localparam int             CNT_W   = $clog2(CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

    logic [WIDTH-1:0] r_sync [STAGES];
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Counter saturates so a long-held value keeps refreshing stable harmlessly.
    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign o_stable  = r_stable;

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= RST_VAL;
            end
            r_cand   <= RST_VAL;
            r_stable <= RST_VAL;
            r_cnt    <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            if (r_sync[STAGES-1] != r_cand) begin
                r_cand <= r_sync[STAGES-1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= w_cnt_nxt;
                if (w_cnt_nxt == CNT_MAX) begin
                    r_stable <= r_cand;
                end
            end
        end
    end

endmodule

// File: rtl/dsp_cfg_sequencer.sv
// Applies debounced switch settings to the DSP on I2S packet boundaries,
// muting and resetting the core while its delay line refills.
module dsp_cfg_sequencer #(
    parameter int         SYNC_STAGES     = 2,
    parameter int         DEBOUNCE_CYCLES = 1024,
    parameter int         FLUSH_PKTS      = 4,
    parameter int         WDOG_CYCLES     = 4096,
    parameter logic [3:0] FREQ_RST        = dsp_cfg_pkg::FREQ_RST,
    parameter logic [3:0] SCALE_RST       = dsp_cfg_pkg::SCALE_RST
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic [3:0] freqSw_i,
    input  logic [3:0] scaleSw_i,
    input  logic       pktStrobe_i,
    output logic [3:0] freqSetting_o,
    output logic [3:0] scaleFactor_o,
    output logic       dspRst_n_o,
    output logic       mute_o,
    output logic       cfgUpdate_o,
    output logic       stall_o
);

    import dsp_cfg_pkg::*;

    localparam int              WD_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);
    localparam int              PK_W    = $clog2(FLUSH_PKTS + 1);
    localparam logic [PK_W-1:0] PK_LAST = PK_W'(FLUSH_PKTS - 1);
    localparam cfg_t            CFG_RST = {FREQ_RST, SCALE_RST};

    logic [7:0]      w_sw_stable;
    cfg_t            w_stable;
    state_e          r_state;
    cfg_t            r_pending;
    cfg_t            r_applied;
    logic            r_mute;
    logic            r_upd;
    logic            r_dsprst_n;
    logic            r_stall;
    logic [WD_W-1:0] r_wdog;
    logic [WD_W-1:0] w_wdog_nxt;
    logic [PK_W-1:0] r_pkt_cnt;

    sw_debouncer #(
        .WIDTH   (8),
        .STAGES  (SYNC_STAGES),
        .CYCLES  (DEBOUNCE_CYCLES),
        .RST_VAL (CFG_RST)
    ) u_sw_debouncer (
        .sclk     (sclk),
        .rst      (rst),
        .i_async  ({freqSw_i, scaleSw_i}),
        .o_stable (w_sw_stable)
    );

    assign w_stable = w_sw_stable;

    // stall_o tracks the counter it is registered alongside, so it drops together with the clear.
    assign w_wdog_nxt = pktStrobe_i          ? '0     :
                        (r_wdog == WD_MAX)   ? r_wdog : r_wdog + 1'b1;

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_wdog  <= '0;
            r_stall <= 1'b0;
        end else begin
            r_wdog  <= w_wdog_nxt;
            r_stall <= (w_wdog_nxt == WD_MAX);
        end
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pending  <= CFG_RST;
            r_applied  <= CFG_RST;
            r_mute     <= 1'b0;
            r_upd      <= 1'b0;
            r_dsprst_n <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            r_upd      <= 1'b0;
            r_dsprst_n <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_stable != r_applied) begin
                        r_pending <= w_stable;
                        r_state   <= WAIT_PKT;
                    end
                end
                WAIT_PKT: begin
                    r_pending <= w_stable;
                    if (w_stable == r_applied) begin
                        r_state <= IDLE;
                    end else if (pktStrobe_i || r_stall) begin
                        r_mute  <= 1'b1;
                        r_state <= APPLY;
                    end
                end
                APPLY: begin
                    // Only a frequency change invalidates the DSP delay line.
                    r_applied  <= r_pending;
                    r_upd      <= 1'b1;
                    r_dsprst_n <= (r_pending.freq == r_applied.freq);
                    r_pkt_cnt  <= '0;
                    r_state    <= FLUSH;
                end
                FLUSH: begin
                    if (r_stall || (pktStrobe_i && (r_pkt_cnt == PK_LAST))) begin
                        r_mute  <= 1'b0;
                        r_state <= IDLE;
                    end else if (pktStrobe_i) begin
                        r_pkt_cnt <= r_pkt_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign freqSetting_o = r_applied.freq;
    assign scaleFactor_o = r_applied.scale;
    assign dspRst_n_o    = r_dsprst_n;
    assign mute_o        = r_mute;
    assign cfgUpdate_o   = r_upd;
    assign stall_o       = r_stall;

endmodule

// File: tb/tb_dsp_cfg_sequencer.sv
// Directed bench for dsp_cfg_sequencer: reset, apply sequences, bounce, flush hold, watchdog.
module tb_dsp_cfg_sequencer;

    logic       sclk = 1'b0;
    logic       rst;
    logic [3:0] freqSw_i;
    logic [3:0] scaleSw_i;
    logic       pktStrobe_i;
    logic [3:0] freqSetting_o;
    logic [3:0] scaleFactor_o;
    logic       dspRst_n_o;
    logic       mute_o;
    logic       cfgUpdate_o;
    logic       stall_o;

    logic gen_en    = 1'b0;
    logic force_pkt = 1'b0;
    int   phase;
    int   upd_cnt   = 0;
    int   n_chk     = 0;
    int   n_err     = 0;

    dsp_cfg_sequencer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .FLUSH_PKTS      (2),
        .WDOG_CYCLES     (64),
        .FREQ_RST        (4'b0001),
        .SCALE_RST       (4'b0001)
    ) dut (
        .sclk          (sclk),
        .rst           (rst),
        .freqSw_i      (freqSw_i),
        .scaleSw_i     (scaleSw_i),
        .pktStrobe_i   (pktStrobe_i),
        .freqSetting_o (freqSetting_o),
        .scaleFactor_o (scaleFactor_o),
        .dspRst_n_o    (dspRst_n_o),
        .mute_o        (mute_o),
        .cfgUpdate_o   (cfgUpdate_o),
        .stall_o       (stall_o)
    );

    always #5 sclk = ~sclk;

    // Packet strobe source: one pulse every 32 cycles when enabled, plus manual pulses.
    initial begin
        pktStrobe_i = 1'b0;
        phase       = 0;
        forever begin
            @(negedge sclk);
            phase       = (phase == 31) ? 0 : phase + 1;
            pktStrobe_i = force_pkt || (gen_en && (phase == 0));
        end
    end

    initial begin
        forever begin
            @(negedge sclk);
            if (cfgUpdate_o === 1'b1) upd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_apply(input string tag, input logic [3:0] ef, input logic [3:0] es,
                              input logic rst_pulse);
        int n;
        n = 0;
        while (!mute_o && n < 200) begin
            tick;
            n++;
        end
        chk({tag, "_mute_rise"}, mute_o, 1'b1);
        chk({tag, "_trigger"}, pktStrobe_i | stall_o, 1'b1);
        chk({tag, "_upd_early"}, cfgUpdate_o, 1'b0);
        tick;
        chk({tag, "_upd"}, cfgUpdate_o, 1'b1);
        chk({tag, "_freq"}, freqSetting_o, ef);
        chk({tag, "_scale"}, scaleFactor_o, es);
        chk({tag, "_dsprst"}, dspRst_n_o, !rst_pulse);
        tick;
        chk({tag, "_upd_end"}, cfgUpdate_o, 1'b0);
        chk({tag, "_dsprst_end"}, dspRst_n_o, 1'b1);
    endtask

    task automatic flush_wait(input string tag, input int exp_strobes);
        int n;
        int c;
        n = 0;
        c = 0;
        do begin
            tick;
            n++;
            if (pktStrobe_i) c++;
        end while (mute_o && n < 300);
        chk({tag, "_mute_fall"}, mute_o, 1'b0);
        chk({tag, "_flush_strobes"}, c, exp_strobes);
    endtask

    initial begin
        int n;
        int u0;
        rst       = 1'b0;
        freqSw_i  = 4'h3;
        scaleSw_i = 4'h5;
        repeat (4) tick;
        chk("rst_freq", freqSetting_o, 4'h1);
        chk("rst_scale", scaleFactor_o, 4'h1);
        chk("rst_dsprst", dspRst_n_o, 1'b0);
        chk("rst_mute", mute_o, 1'b0);
        chk("rst_upd", cfgUpdate_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        rst = 1'b1;
        tick;
        chk("rel_dsprst", dspRst_n_o, 1'b1);
        chk("rel_freq", freqSetting_o, 4'h1);
        gen_en = 1'b1;
        wait_apply("init35", 4'h3, 4'h5, 1'b1);

        // Asynchronous reset while muted in FLUSH.
        freqSw_i  = 4'h1;
        scaleSw_i = 4'h1;
        #2 rst = 1'b0;
        #1;
        chk("arst_mute", mute_o, 1'b0);
        chk("arst_freq", freqSetting_o, 4'h1);
        chk("arst_scale", scaleFactor_o, 4'h5 & 4'h1);
        chk("arst_dsprst", dspRst_n_o, 1'b0);
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk("arst_rel_dsprst", dspRst_n_o, 1'b1);
        u0 = upd_cnt;
        repeat (80) tick;
        chk("arst_no_upd", upd_cnt - u0, 0);
        chk("arst_idle_mute", mute_o, 1'b0);

        freqSw_i = 4'h4;
        wait_apply("freq4", 4'h4, 4'h1, 1'b1);
        flush_wait("freq4", 2);

        // Scale-only change with exact latency: strobe on WAIT_PKT entry is ignored.
        gen_en    = 1'b0;
        scaleSw_i = 4'h7;
        repeat (10) tick;
        force_pkt = 1'b1;
        tick;
        chk("lat_entry_strobe_ignored", mute_o, 1'b0);
        tick;
        chk("lat_next_strobe_seen", mute_o, 1'b1);
        force_pkt = 1'b0;
        tick;
        chk("scale7_upd", cfgUpdate_o, 1'b1);
        chk("scale7_scale", scaleFactor_o, 4'h7);
        chk("scale7_freq", freqSetting_o, 4'h4);
        chk("scale7_dsprst", dspRst_n_o, 1'b1);
        tick;
        chk("scale7_upd_end", cfgUpdate_o, 1'b0);
        gen_en = 1'b1;
        flush_wait("scale7", 2);

        u0 = upd_cnt;
        for (int i = 0; i < 8; i++) begin
            freqSw_i = (i % 2 == 1) ? 4'h3 : 4'h5;
            repeat (5) tick;
        end
        chk("bounce_no_upd", upd_cnt - u0, 0);
        chk("bounce_no_mute", mute_o, 1'b0);
        chk("bounce_freq_held", freqSetting_o, 4'h4);
        freqSw_i = 4'h2;
        wait_apply("bounce2", 4'h2, 4'h7, 1'b1);
        flush_wait("bounce2", 2);
        chk("bounce_single_upd", upd_cnt - u0, 1);

        scaleSw_i = 4'h3;
        wait_apply("scale3", 4'h2, 4'h3, 1'b0);
        scaleSw_i = 4'h9;
        flush_wait("scale3", 2);
        chk("flush_change_held", scaleFactor_o, 4'h3);
        wait_apply("scale9", 4'h2, 4'h9, 1'b0);
        flush_wait("scale9", 2);

        // Watchdog: stop strobes right after one and count idle cycles to stall.
        n = 0;
        while (!pktStrobe_i && n < 40) begin
            tick;
            n++;
        end
        chk("wd_sync_strobe", pktStrobe_i, 1'b1);
        gen_en   = 1'b0;
        freqSw_i = 4'h6;
        n = 0;
        while (!stall_o && n < 200) begin
            tick;
            n++;
        end
        chk("wd_stall_cycles", n, 64);
        chk("wd_no_mute_before_stall", mute_o, 1'b0);
        tick;
        chk("wd_mute", mute_o, 1'b1);
        chk("wd_upd_early", cfgUpdate_o, 1'b0);
        tick;
        chk("wd_upd", cfgUpdate_o, 1'b1);
        chk("wd_freq", freqSetting_o, 4'h6);
        chk("wd_scale", scaleFactor_o, 4'h9);
        chk("wd_dsprst", dspRst_n_o, 1'b0);
        tick;
        chk("wd_upd_end", cfgUpdate_o, 1'b0);
        chk("wd_flush_exit", mute_o, 1'b0);
        chk("wd_stall_held", stall_o, 1'b1);
        gen_en = 1'b1;
        n = 0;
        do begin
            tick;
            n++;
        end while (!pktStrobe_i && n < 40);
        chk("wd_strobe_arrived", pktStrobe_i, 1'b1);
        chk("wd_stall_clear", stall_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
